// File: rtl/ltssm_tsos_rx_checker.sv
// Receive-side TS1/TS2 ordered-set checker: validates 16-symbol sets per lane and tracks consecutive good sets.
// Optional LTSSM_TSOS_RX_ERR_CNT_EN adds a saturating err_cnt_o for malformed/aborted/bad-COM beats.
module ltssm_tsos_rx_checker #(
    parameter int MAX_NUM_LANES = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH/8,
    parameter int USER_WIDTH    = 8,
    parameter int TS_COUNT      = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep_i,
    input  logic                     s_axis_tvalid_i,
    input  logic                     s_axis_tlast_i,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser_i,
    output logic                     s_axis_tready_o,
`ifdef LTSSM_TSOS_RX_ERR_CNT_EN
    output logic [15:0]              err_cnt_o,
`endif
    output logic [MAX_NUM_LANES-1:0] lanes_ts1_satisfied_o,
    output logic [MAX_NUM_LANES-1:0] lanes_ts2_satisfied_o
);

    localparam int              CW         = $clog2(TS_COUNT + 1);
    localparam logic [CW-1:0]   CNT_MAX    = CW'(TS_COUNT);
    localparam logic [3:0]      LANE_LIMIT = 4'(MAX_NUM_LANES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EVAL
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  lane_q;
    logic [1:0]  beat_idx_q;
    logic        is_ts1_q, is_ts2_q;

    logic [CW-1:0] ts1_cnt_q [MAX_NUM_LANES];
    logic [CW-1:0] ts2_cnt_q [MAX_NUM_LANES];

    logic [2:0]  beat_lane;
    logic        accept, keep_ok, os_beat, com_ok, lane_ok;
    logic        beat_ts1, beat_ts2;
    logic        do_start, do_store, do_abort, do_eval;
    logic        set_ts1, set_ts2, set_clr;

    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tlast_i, s_axis_tuser_i[USER_WIDTH-1:4]};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    assign s_axis_tready_o = (state_q != ST_EVAL);
    assign beat_lane       = s_axis_tuser_i[3:1];

    always_comb begin
        accept  = s_axis_tvalid_i & s_axis_tready_o;
        keep_ok = &s_axis_tkeep_i;
        os_beat = s_axis_tuser_i[0];
        com_ok  = (s_axis_tdata_i[7:0] == 8'hBC);
        lane_ok = ({1'b0, beat_lane} < LANE_LIMIT);
        // beat1 carries symbols 4-7; only 6 and 7 belong to the identifier field
        if (beat_idx_q == 2'd1) begin
            beat_ts1 = (s_axis_tdata_i[31:16] == 16'h4A4A);
            beat_ts2 = (s_axis_tdata_i[31:16] == 16'h4545);
        end else begin
            beat_ts1 = (s_axis_tdata_i == 32'h4A4A_4A4A);
            beat_ts2 = (s_axis_tdata_i == 32'h4545_4545);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_start = 1'b0;
        do_store = 1'b0;
        do_abort = 1'b0;
        do_eval  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && os_beat && keep_ok && com_ok && lane_ok) begin
                    do_start = 1'b1;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (os_beat && (beat_lane == lane_q) && keep_ok) begin
                        do_store = 1'b1;
                        if (beat_idx_q == 2'd3) begin
                            state_d = ST_EVAL;
                        end
                    end else begin
                        do_abort = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_EVAL: begin
                do_eval = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en_i) begin
            state_d  = ST_IDLE;
            do_start = 1'b0;
            do_store = 1'b0;
            do_abort = 1'b0;
            do_eval  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q     <= '0;
            beat_idx_q <= '0;
            is_ts1_q   <= 1'b0;
            is_ts2_q   <= 1'b0;
        end else if (do_start) begin
            lane_q     <= beat_lane;
            beat_idx_q <= 2'd1;
            is_ts1_q   <= 1'b1;
            is_ts2_q   <= 1'b1;
        end else if (do_store) begin
            beat_idx_q <= beat_idx_q + 2'd1;
            is_ts1_q   <= is_ts1_q & beat_ts1;
            is_ts2_q   <= is_ts2_q & beat_ts2;
        end
    end

    always_comb begin
        set_ts1 = do_eval & is_ts1_q;
        set_ts2 = do_eval & is_ts2_q;
        set_clr = do_abort | (do_eval & ~is_ts1_q & ~is_ts2_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned l = 0; l < MAX_NUM_LANES; l++) begin
                ts1_cnt_q[l] <= '0;
                ts2_cnt_q[l] <= '0;
            end
        end else if (!en_i) begin
            for (int unsigned l = 0; l < MAX_NUM_LANES; l++) begin
                ts1_cnt_q[l] <= '0;
                ts2_cnt_q[l] <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < MAX_NUM_LANES; l++) begin
                if (lane_q == 3'(l)) begin
                    if (set_clr) begin
                        ts1_cnt_q[l] <= '0;
                        ts2_cnt_q[l] <= '0;
                    end else if (set_ts2) begin
                        ts1_cnt_q[l] <= sat_inc(ts1_cnt_q[l]);
                        ts2_cnt_q[l] <= sat_inc(ts2_cnt_q[l]);
                    end else if (set_ts1) begin
                        ts1_cnt_q[l] <= sat_inc(ts1_cnt_q[l]);
                        ts2_cnt_q[l] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        lanes_ts1_satisfied_o = '0;
        lanes_ts2_satisfied_o = '0;
        for (int unsigned l = 0; l < MAX_NUM_LANES; l++) begin
            lanes_ts1_satisfied_o[l] = (ts1_cnt_q[l] == CNT_MAX);
            lanes_ts2_satisfied_o[l] = (ts2_cnt_q[l] == CNT_MAX);
        end
    end

`ifdef LTSSM_TSOS_RX_ERR_CNT_EN
    logic err_evt;

    always_comb begin
        err_evt = set_clr |
                  (en_i & (state_q == ST_IDLE) & accept & os_beat & (~com_ok | ~lane_ok));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (!en_i) begin
            err_cnt_o <= '0;
        end else if (err_evt && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ltssm_tsos_rx_checker.sv
// Directed bench for ltssm_tsos_rx_checker: per-lane run-length model checked every cycle plus literal spot checks.
module tb_ltssm_tsos_rx_checker;

    localparam int LANES = 4;
    localparam int TS_N  = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i  = 1'b1;
    logic [31:0] s_axis_tdata_i  = '0;
    logic [3:0]  s_axis_tkeep_i  = 4'hF;
    logic        s_axis_tvalid_i = 1'b0;
    logic        s_axis_tlast_i  = 1'b0;
    logic [7:0]  s_axis_tuser_i  = '0;
    logic        s_axis_tready_o;
    logic [3:0]  lanes_ts1_satisfied_o;
    logic [3:0]  lanes_ts2_satisfied_o;
`ifdef LTSSM_TSOS_RX_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    ltssm_tsos_rx_checker #(
        .MAX_NUM_LANES(LANES),
        .DATA_WIDTH(32),
        .USER_WIDTH(8),
        .TS_COUNT(TS_N)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i(en_i),
        .s_axis_tdata_i(s_axis_tdata_i),
        .s_axis_tkeep_i(s_axis_tkeep_i),
        .s_axis_tvalid_i(s_axis_tvalid_i),
        .s_axis_tlast_i(s_axis_tlast_i),
        .s_axis_tuser_i(s_axis_tuser_i),
        .s_axis_tready_o(s_axis_tready_o),
`ifdef LTSSM_TSOS_RX_ERR_CNT_EN
        .err_cnt_o(err_cnt_o),
`endif
        .lanes_ts1_satisfied_o(lanes_ts1_satisfied_o),
        .lanes_ts2_satisfied_o(lanes_ts2_satisfied_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    // Model: length of the current unbroken run of good sets per lane (unbounded).
    int run_any [LANES];
    int run_ts2 [LANES];
    logic exp_tready = 1'b1;
    logic cmp_on     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] exp_ts1();
        logic [3:0] r = '0;
        for (int l = 0; l < LANES; l++) r[l] = (run_any[l] >= TS_N);
        return r;
    endfunction

    function automatic logic [3:0] exp_ts2();
        logic [3:0] r = '0;
        for (int l = 0; l < LANES; l++) r[l] = (run_ts2[l] >= TS_N);
        return r;
    endfunction

    task automatic model_clear_all();
        for (int l = 0; l < LANES; l++) begin
            run_any[l] = 0;
            run_ts2[l] = 0;
        end
    endtask

    always @(negedge clk_i) begin
        if (cmp_on) begin
            chk("tready", {31'b0, s_axis_tready_o}, {31'b0, exp_tready});
            chk("ts1_sat", {28'b0, lanes_ts1_satisfied_o}, {28'b0, exp_ts1()});
            chk("ts2_sat", {28'b0, lanes_ts2_satisfied_o}, {28'b0, exp_ts2()});
        end
    end

    // Drives one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [31:0] d, input int lane, input logic os);
        logic was_ready;
        int   tries = 0;
        s_axis_tdata_i  = d;
        s_axis_tuser_i  = {4'b0, 3'(lane), os};
        s_axis_tvalid_i = 1'b1;
        forever begin
            was_ready = s_axis_tready_o;
            @(posedge clk_i);
            #1;
            if (was_ready) break;
            tries++;
            if (tries > 8) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        s_axis_tvalid_i = 1'b0;
    endtask

    task automatic send_set(input int lane, input bit ts2, input int bad);
        logic [7:0] sym [16];
        bit all1 = 1'b1;
        bit all2 = 1'b1;
        sym[0] = 8'hBC;
        for (int i = 1; i < 6; i++) sym[i] = 8'(16 * i + lane);
        for (int i = 6; i < 16; i++) sym[i] = ts2 ? 8'h45 : 8'h4A;
        if (bad >= 0) sym[bad] = 8'h00;
        for (int b = 0; b < 4; b++)
            send_beat({sym[4*b+3], sym[4*b+2], sym[4*b+1], sym[4*b]}, lane, 1'b1);
        exp_tready = 1'b0;
        @(posedge clk_i);
        #1;
        for (int i = 6; i < 16; i++) begin
            if (sym[i] != 8'h4A) all1 = 1'b0;
            if (sym[i] != 8'h45) all2 = 1'b0;
        end
        if (all1) begin
            run_any[lane]++;
            run_ts2[lane] = 0;
        end else if (all2) begin
            run_any[lane]++;
            run_ts2[lane]++;
        end else begin
            run_any[lane] = 0;
            run_ts2[lane] = 0;
        end
        exp_tready = 1'b1;
    endtask

    task automatic lit(input string name, input logic [3:0] t1, input logic [3:0] t2);
        chk({name, "_ts1"}, {28'b0, lanes_ts1_satisfied_o}, {28'b0, t1});
        chk({name, "_ts2"}, {28'b0, lanes_ts2_satisfied_o}, {28'b0, t2});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear_all();
        repeat (3) @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        cmp_on = 1'b1;
        chk("rst_tready", {31'b0, s_axis_tready_o}, 32'd1);
        lit("rst", 4'b0000, 4'b0000);

        for (int i = 0; i < 7; i++) send_set(0, 1'b0, -1);
        lit("l0_7ts1", 4'b0000, 4'b0000);
        send_set(0, 1'b0, -1);
        lit("l0_8ts1", 4'b0001, 4'b0000);

        for (int i = 0; i < 8; i++) send_set(2, 1'b1, -1);
        lit("l2_8ts2", 4'b0101, 4'b0100);
        send_set(2, 1'b1, -1);
        lit("l2_9ts2", 4'b0101, 4'b0100);

        for (int i = 0; i < 7; i++) send_set(1, 1'b1, -1);
        lit("l1_7ts2", 4'b0101, 4'b0100);
        send_set(1, 1'b0, -1);
        lit("l1_ts1", 4'b0111, 4'b0100);
        for (int i = 0; i < 7; i++) send_set(1, 1'b1, -1);
        lit("l1_7more", 4'b0111, 4'b0100);
        send_set(1, 1'b1, -1);
        lit("l1_8more", 4'b0111, 4'b0110);

        for (int i = 0; i < 5; i++) send_set(0, 1'b0, -1);
        send_set(0, 1'b0, 10);
        lit("l0_bad", 4'b0110, 4'b0110);
`ifdef LTSSM_TSOS_RX_ERR_CNT_EN
        chk("err_cnt_bad", {16'b0, err_cnt_o}, 32'd1);
`endif
        for (int i = 0; i < 7; i++) send_set(0, 1'b0, -1);
        lit("l0_7after", 4'b0110, 4'b0110);
        send_set(0, 1'b0, -1);
        lit("l0_8after", 4'b0111, 4'b0110);

        for (int i = 0; i < 8; i++) send_set(3, 1'b1, -1);
        lit("l3_sat", 4'b1111, 4'b1110);
        send_beat(32'h1030_20BC, 3, 1'b1);
        send_beat(32'h4545_6353, 3, 1'b1);
        send_beat(32'h4545_4545, 3, 1'b0);
        run_any[3] = 0;
        run_ts2[3] = 0;
        lit("l3_abort_os", 4'b0111, 4'b0110);

        for (int i = 0; i < 8; i++) send_set(3, 1'b1, -1);
        send_beat(32'h1030_20BC, 3, 1'b1);
        send_beat(32'h4545_6353, 3, 1'b1);
        send_beat(32'h1030_20BC, 1, 1'b1);
        run_any[3] = 0;
        run_ts2[3] = 0;
        lit("l3_abort_lane", 4'b0111, 4'b0110);

        send_beat(32'h1030_20BD, 0, 1'b1);
        send_beat(32'h1030_20BC, 5, 1'b1);
        lit("idle_drop", 4'b0111, 4'b0110);

        en_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_clear_all();
        en_i = 1'b1;
        lit("en_low", 4'b0000, 4'b0000);

        for (int i = 0; i < 8; i++) send_set(2, 1'b1, -1);
        lit("l2_again", 4'b0100, 4'b0100);
        send_beat(32'h1030_20BC, 0, 1'b1);
        send_beat(32'h4A4A_6050, 0, 1'b1);
        rst_i = 1'b1;
        model_clear_all();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("midrst_tready", {31'b0, s_axis_tready_o}, 32'd1);
        lit("midrst", 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) send_set(0, 1'b0, -1);
        lit("post_rst_l0", 4'b0001, 4'b0000);

        repeat (3) @(posedge clk_i);
        #1;
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
